rle_expand_32: RTL and testbench
================================

// Module: rle_expand_32
// PURPOSE
//  Inverse of the 32-coefficient zero-run merge stage: takes one compacted block
//  {left, right, flag, array, size} and replays it as 32 serial coefficients, one per beat.
//  Sits between the entropy/run-length front end and the IDCT input buffer.
//  Valid/ready on both sides. One block is in flight at a time.
// PARAMETERS
//  COEF_W   8   coefficient value width; entry bits [COEF_W-1:0]
//  RUN_W    6   preceding-zero-run width; entry bits [COEF_W+RUN_W-1:COEF_W]
//  N_COEF   32  coefficients per block; also the maximum entry count
//  (entry width EW = RUN_W+COEF_W = 14; defaults must match the merge stage)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  in_valid   in   1          block present on in_* inputs
//  in_ready   out  1          block accepted when in_valid & in_ready
//  in_left    in   5          leading zero count, 0..31
//  in_right   in   5          trailing zero count, 0..31
//  in_flag    in   1          0 = all-zero block (other in_* ignored)
//  in_array   in   N_COEF*EW  entries; entry i = in_array[EW*i +: EW]; entry size-1 is first
//  in_size    in   6          number of valid entries, 0..32
//  out_valid  out  1          out_data valid
//  out_ready  in   1          sink accepts beat when out_valid & out_ready
//  out_data   out  COEF_W     coefficient value
//  out_last   out  1          high on the 32nd beat of a block
//  out_err    out  1          block length mismatch; meaningful only with out_last
// BEHAVIOUR
//  Reset: in_ready=0 while rst is high, then 1 on the first cycle after release.
//    out_valid=0, out_data=0, out_last=0, out_err=0. State=IDLE and all counters cleared.
//  FSM: IDLE -> LEAD -> (RUN -> VAL)* -> TRAIL -> IDLE. PAD is reached only on underrun.
//    IDLE : in_ready=1. On handshake, register every in_* field and go to LEAD.
//           in_ready=0 in all other states.
//    LEAD : emit in_left zeros.
//    RUN  : emit run zeros for entry idx. idx starts at size-1 and counts down.
//    VAL  : emit the entry's value; then idx-1, or TRAIL after entry 0.
//    TRAIL: emit in_right zeros.
//    PAD  : emit zeros until 32 beats.
//  Zero-length phases (left=0, run=0, right=0, size=0) consume no cycles. There are no
//    bubbles: with out_ready held high, the 32 beats are on consecutive cycles.
//  Latency: handshake at cycle N -> first beat valid at N+1. After out_last is accepted,
//    the block returns to IDLE, so in_ready=1 one cycle later (one bubble between blocks).
//  Backpressure: while out_valid & ~out_ready, out_data, out_last and out_err hold stable.
//  Beat counter is 6 bits. Exactly 32 beats are emitted per block, always.
//  flag=0: 32 zero beats. left, right, array and size are ignored.
//  Expected length L = left + sum over entries(run+1) + right, computed at the widths
//    needed to avoid overflow.
//    L>32 (overrun): stop at beat 32; the remaining content is dropped.
//    L<32 (underrun): after TRAIL, go to PAD and emit zeros to beat 32.
//  in_size>32 is clamped to 32 and counts as a mismatch.
//  Reset mid-block: the block is abandoned; there is no partial last beat.
// CONFIGURATION
//  RLE_EXPAND_ERR_EN defined: out_err=1 on the last beat when L!=32 or in_size>32; else 0.
//  RLE_EXPAND_ERR_EN undefined: the length check is not built and out_err is tied 0.
//    Truncate/pad to 32 beats still applies.
// TESTING
//  1 flag=0 -> 32 zero beats, out_last on beat 31, out_err=0.
//  2 left=3, right=2, size=3, e2={0,0x11}, e1={4,0x22}, e0={20,0x33}
//    -> beats 0-2 =0, 3 =0x11, 4-7 =0, 8 =0x22, 9-28 =0, 29 =0x33, 30-31 =0, err=0.
//  3 Test 2 with out_ready toggled every cycle
//    -> same 32 values; out_data stable during stalls; 63 cycles from first valid.
//  4 size=32, left=right=0, all runs 0, values 1..32 with e31=1
//    -> beats 1..32 on 32 consecutive cycles, then in_ready=1 next cycle.
//  5 Err (macro on): left=20, right=20, size=0 -> 32 zeros, out_err=1 with out_last.
//    left=1, right=1, size=1, e0={0,0x05} -> 0, 0x05, 0, then 29 pad zeros, out_err=1.
//  6 Assert rst during beat 10 of test 2 -> out_valid=0 immediately.
//    After release, in_ready=1 and a new test-1 block produces exactly 32 beats.

Source files
------------

// File: rtl/rle_expand_32.sv
// rle_expand_32: replays one compacted zero-run block as 32 serial coefficients; define RLE_EXPAND_ERR_EN to build the length-mismatch flag
module rle_expand_32 #(
  parameter int COEF_W = 8,
  parameter int RUN_W = 6,
  parameter int N_COEF = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [4:0] in_left,
  input  logic [4:0] in_right,
  input  logic in_flag,
  input  logic [N_COEF*(RUN_W+COEF_W)-1:0] in_array,
  input  logic [5:0] in_size,
  output logic out_valid,
  input  logic out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic out_last,
  output logic out_err
);
  localparam int EW = RUN_W + COEF_W;
  localparam int IW = $clog2(N_COEF);
  localparam int CW = RUN_W > 5 ? RUN_W : 5;
  typedef enum logic [2:0] {IDLE, LEAD, RUN, VAL, TRAIL, PAD} state_t;
  state_t state, st_p, en_p, nx_p;
  logic [CW-1:0] cnt, st_c, en_c, nx_c;
  logic [IW-1:0] idx, s_idx, e_idx, nx_i;
  logic [4:0] right_r;
  logic [5:0] size_c, size_r, beat;
  logic [N_COEF*EW-1:0] arr_r;
  logic [RUN_W-1:0] run_i [N_COEF];
  logic [RUN_W-1:0] run_r [N_COEF];
  logic [COEF_W-1:0] val_i [N_COEF];
  logic [COEF_W-1:0] val_r [N_COEF];
  logic has_e, err_c, err_r;
  always_comb
    for (int k = 0; k < N_COEF; k++) begin
      {run_i[k], val_i[k]} = in_array[EW*k +: EW];
      {run_r[k], val_r[k]} = arr_r[EW*k +: EW];
    end
  // state/cnt/idx always describe the beat currently on out_*, so empty phases are skipped when entered
  always_comb begin
    size_c = in_size > 6'(N_COEF) ? 6'(N_COEF) : in_size;
    s_idx = IW'(size_c - 6'd1);
    st_p = !in_flag ? PAD : in_left != 5'd0 ? LEAD : size_c == 6'd0 ? (in_right != 5'd0 ? TRAIL : PAD) : run_i[s_idx] != '0 ? RUN : VAL;
    st_c = st_p == LEAD ? CW'(in_left) : st_p == RUN ? CW'(run_i[s_idx]) : CW'(in_right);
  end
  always_comb begin
    has_e = state == VAL ? idx != '0 : size_r != 6'd0;
    e_idx = state == VAL ? idx - 1'b1 : IW'(size_r - 6'd1);
    en_p = !has_e ? (right_r != 5'd0 ? TRAIL : PAD) : run_r[e_idx] != '0 ? RUN : VAL;
    en_c = has_e ? CW'(run_r[e_idx]) : CW'(right_r);
    nx_p = (state == LEAD || state == RUN || state == TRAIL) && cnt > CW'(1) ? state : state == RUN ? VAL : (state == TRAIL || state == PAD) ? PAD : en_p;
    nx_c = nx_p == state ? cnt - 1'b1 : en_c;
    nx_i = state == RUN ? idx : e_idx;
  end
`ifdef RLE_EXPAND_ERR_EN
  logic [15:0] len;
  always_comb begin
    len = 16'(in_left) + 16'(in_right);
    for (int k = 0; k < N_COEF; k++)
      if (k < int'(size_c)) len = len + 16'(run_i[k]) + 16'd1;
    err_c = in_flag && (len != 16'(N_COEF) || in_size > 6'(N_COEF));
  end
`else
  assign err_c = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_err <= 1'b0;
      cnt <= '0;
      idx <= '0;
      beat <= '0;
      right_r <= '0;
      size_r <= '0;
      arr_r <= '0;
      err_r <= 1'b0;
    end else if (state == IDLE) begin
      in_ready <= !(in_valid && in_ready);
      if (in_valid && in_ready) begin
        state <= st_p;
        cnt <= st_c;
        idx <= s_idx;
        beat <= '0;
        right_r <= in_right;
        size_r <= size_c;
        arr_r <= in_array;
        err_r <= err_c;
        out_valid <= 1'b1;
        out_data <= st_p == VAL ? val_i[s_idx] : '0;
        out_last <= 1'b0;
        out_err <= 1'b0;
      end
    end else if (out_ready) begin
      if (out_last) begin
        state <= IDLE;
        in_ready <= 1'b1;
        out_valid <= 1'b0;
        out_data <= '0;
        out_last <= 1'b0;
        out_err <= 1'b0;
      end else begin
        state <= nx_p;
        cnt <= nx_c;
        idx <= nx_i;
        beat <= beat + 6'd1;
        out_data <= nx_p == VAL ? val_r[nx_i] : '0;
        out_last <= beat == 6'(N_COEF - 2);
        out_err <= err_r && beat == 6'(N_COEF - 2);
      end
    end
endmodule

// File: tb/tb_rle_expand_32.sv
// tb_rle_expand_32: scoreboard bench; a list-expansion model predicts each block's 32 beats
module tb_rle_expand_32;
  localparam int EW = 14;
  logic clk, rst, in_valid, in_ready, in_flag, out_valid, out_ready, out_last, out_err;
  logic [4:0] in_left, in_right;
  logic [32*EW-1:0] in_array;
  logic [5:0] in_size;
  logic [7:0] out_data;
  typedef struct {logic [7:0] d; logic l; logic e; int span;} exp_t;
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  int rmode = 0, blk = 0, span = 0;
  logic [5:0] b_run [32];
  logic [7:0] b_val [32];
  int b_left, b_right, b_size;
  logic b_flag;

  rle_expand_32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .in_flag(in_flag), .in_array(in_array),
    .in_size(in_size), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_err(out_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Reference: concatenate the phases as a list, then truncate or zero-pad to 32
  task automatic push_model(input int sp);
    int q[$];
    int sz;
    bit bad;
    exp_t e;
    sz = b_size > 32 ? 32 : b_size;
    if (b_flag) begin
      repeat (b_left) q.push_back(0);
      for (int i = sz - 1; i >= 0; i--) begin
        repeat (b_run[i]) q.push_back(0);
        q.push_back(int'(b_val[i]));
      end
      repeat (b_right) q.push_back(0);
    end
    bad = b_flag && (q.size() != 32 || b_size > 32);
`ifndef RLE_EXPAND_ERR_EN
    bad = 0;
`endif
    while (q.size() < 32) q.push_back(0);
    for (int i = 0; i < 32; i++) begin
      e.d = 8'(q[i]);
      e.l = i == 31;
      e.e = i == 31 && bad;
      e.span = i == 31 ? sp : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic send();
    int n;
    int sp;
    n = 0;
    @(negedge clk);
    in_flag = b_flag;
    in_left = 5'(b_left);
    in_right = 5'(b_right);
    in_size = 6'(b_size);
    for (int i = 0; i < 32; i++) in_array[EW*i +: EW] = {b_run[i], b_val[i]};
    in_valid = 1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
      in_valid = 0;
      return;
    end
    sp = rmode == 0 ? 32 : rmode == 1 ? 63 : 0;
    @(posedge clk);
    push_model(sp);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_blk();
    b_flag = 1;
    b_left = 0;
    b_right = 0;
    b_size = 0;
    for (int i = 0; i < 32; i++) begin
      b_run[i] = 0;
      b_val[i] = 0;
    end
  endtask

  task automatic set_t2();
    clear_blk();
    b_left = 3;
    b_right = 2;
    b_size = 3;
    b_run[2] = 0;  b_val[2] = 8'h11;
    b_run[1] = 4;  b_val[1] = 8'h22;
    b_run[0] = 20; b_val[0] = 8'h33;
  endtask

  task automatic rand_blk();
    int s;
    b_flag = $urandom_range(0, 9) != 0;
    b_size = $urandom_range(0, 9) == 0 ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 12));
    for (int i = 0; i < 32; i++) begin
      b_run[i] = 6'($urandom_range(0, 3) == 0 ? $urandom_range(0, 63) : $urandom_range(0, 4));
      b_val[i] = 8'($urandom);
    end
    b_left = $urandom_range(0, 8);
    s = b_left;
    for (int i = 0; i < 32 && i < b_size; i++) s += int'(b_run[i]) + 1;
    b_right = (s <= 32 && 32 - s <= 31 && $urandom_range(0, 1) == 1) ? 32 - s : int'($urandom_range(0, 31));
  endtask

  // out_ready: mode 0 always, mode 1 alternating starting high on each block's first beat, mode 2 random
  initial begin
    bit hs, tog;
    tog = 0;
    out_ready = 0;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      tog = hs ? 1'b1 : !tog;
      out_ready = rmode == 0 || (rmode == 1 && tog) || (rmode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  initial begin
    exp_t e;
    logic stalled;
    logic [7:0] p_d;
    logic p_l, p_e;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        span = 0;
        blk = 0;
        stalled = 0;
        continue;
      end
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_d);
        chk("stall_last", out_last, p_l);
        chk("stall_err", out_err, p_e);
      end
      stalled = out_valid && !out_ready;
      p_d = out_data;
      p_l = out_last;
      p_e = out_err;
      if (out_valid) span++;
      if (out_valid && out_ready) begin
        blk++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h, want no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.d);
          chk("last", out_last, e.l);
          chk("err", out_err, e.e);
          if (e.l) begin
            if (e.span != 0) chk("span", span, e.span);
            span = 0;
            blk = 0;
            @(negedge clk);
            chk("ready_after_last", in_ready, 1);
            chk("idle_after_last", out_valid, 0);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d beats outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 0;
    in_valid = 0;
    in_flag = 0;
    in_left = 0;
    in_right = 0;
    in_size = 0;
    in_array = '0;
    #2 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_err", out_err, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    clear_blk();
    b_flag = 0; b_left = 7; b_right = 3; b_size = 5; b_run[4] = 2; b_val[4] = 8'h9a;
    send(); drain();
    set_t2(); send(); drain();
    rmode = 1; set_t2(); send(); drain(); rmode = 0;
    clear_blk();
    b_size = 32;
    for (int i = 0; i < 32; i++) b_val[i] = 8'(32 - i);
    send(); drain();
    clear_blk(); b_left = 20; b_right = 20; send(); drain();
    clear_blk(); b_left = 1; b_right = 1; b_size = 1; b_val[0] = 8'h05; send(); drain();
    clear_blk(); b_left = 2; b_size = 34; b_val[31] = 8'h7e; b_val[0] = 8'h01; send(); drain();
    for (int t = 0; t < 40; t++) begin
      rmode = $urandom_range(0, 2);
      rand_blk();
      send();
      drain();
    end
    rmode = 0;
    set_t2();
    send();
    n = 0;
    while (blk < 11 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_beat10", 32'(blk >= 11), 1);
    rst = 1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_last", out_last, 0);
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_mid_rst", in_ready, 1);
    clear_blk();
    b_flag = 0;
    send(); drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
